// File: rtl/vga_scaled_timing.sv
// VGA timing generator with an integer-scaled, centred logical framebuffer.
// Stage 0 holds the raster and logical counters and drives the buffer lookup;
// stage 1 registers colour, sync and the frame-start marker onto the pins.
module vga_scaled_timing #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int SCREEN_W  = 256,
    parameter int SCREEN_H  = 192,
    parameter int SCALE_X   = 4,
    parameter int SCALE_Y   = 4,
    parameter int COLOR_W   = 8,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        video_en,
    output logic [$clog2(SCREEN_W)-1:0] x_coord,
    output logic [$clog2(SCREEN_H)-1:0] y_coord,
    output logic                        pix_req,
    output logic                        invalidate,
    input  logic [COLOR_W-1:0]          pix_data,
    output logic [COLOR_W-1:0]          rgb,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SPAN  = SCREEN_W * SCALE_X;
    localparam int V_SPAN  = SCREEN_H * SCALE_Y;
    localparam int H_OFF_I = (H_ACTIVE - H_SPAN) / 2;
    localparam int V_OFF_I = (V_ACTIVE - V_SPAN) / 2;

    localparam int CXW = $clog2(H_TOTAL + 1);
    localparam int CYW = $clog2(V_TOTAL + 1);
    localparam int XW  = $clog2(SCREEN_W);
    localparam int YW  = $clog2(SCREEN_H);
    localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    localparam logic [CXW-1:0] H_LAST     = CXW'(H_TOTAL - 1);
    localparam logic [CXW-1:0] H_OFF      = CXW'(H_OFF_I);
    localparam logic [CXW-1:0] H_END      = CXW'(H_OFF_I + H_SPAN);
    localparam logic [CXW-1:0] H_END_LAST = CXW'(H_OFF_I + H_SPAN - 1);
    localparam logic [CXW-1:0] H_ACT      = CXW'(H_ACTIVE);
    localparam logic [CXW-1:0] HS_BEG     = CXW'(H_ACTIVE + H_FRONT);
    localparam logic [CXW-1:0] HS_END     = CXW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [CYW-1:0] V_LAST     = CYW'(V_TOTAL - 1);
    localparam logic [CYW-1:0] V_OFF      = CYW'(V_OFF_I);
    localparam logic [CYW-1:0] V_END      = CYW'(V_OFF_I + V_SPAN);
    localparam logic [CYW-1:0] V_ACT      = CYW'(V_ACTIVE);
    localparam logic [CYW-1:0] VS_BEG     = CYW'(V_ACTIVE + V_FRONT);
    localparam logic [CYW-1:0] VS_END     = CYW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);
    localparam logic [XW-1:0]  X_LAST  = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(SCREEN_H - 1);

    localparam logic HS_ON = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

    // A scaled screen larger than the active area cannot be centred.
    if ((H_SPAN > H_ACTIVE) || (V_SPAN > V_ACTIVE)) begin : g_size_err
        $error("vga_scaled_timing: scaled screen exceeds the active area");
    end

    logic [CXW-1:0] cx_r;
    logic [CYW-1:0] cy_r;
    logic [SXW-1:0] sx_r;
    logic [SYW-1:0] sy_r;
    logic [XW-1:0]  x_r;
    logic [YW-1:0]  y_r;

    logic h_ge_s;
    logic v_ge_s;
    logic in_h_s;
    logic in_v_s;
    logic in_scr_s;
    logic active_s;
    logic h_wrap_s;
    logic line_last_s;
    logic pix_req_s;
    logic [COLOR_W-1:0] rgb_nxt_s;
    logic hsync_nxt_s;
    logic vsync_nxt_s;

    // A zero offset makes the lower window bound always true; special-case it
    // so no constant unsigned comparison is generated.
    if (H_OFF_I == 0) begin : g_h_at_zero
        assign h_ge_s = 1'b1;
    end else begin : g_h_offset
        assign h_ge_s = (cx_r >= H_OFF);
    end

    if (V_OFF_I == 0) begin : g_v_at_zero
        assign v_ge_s = 1'b1;
    end else begin : g_v_offset
        assign v_ge_s = (cy_r >= V_OFF);
    end

    assign in_h_s      = h_ge_s && (cx_r < H_END);
    assign in_v_s      = v_ge_s && (cy_r < V_END);
    assign in_scr_s    = in_h_s && in_v_s;
    assign active_s    = (cx_r < H_ACT) && (cy_r < V_ACT);
    assign h_wrap_s    = (cx_r == H_LAST);
    assign line_last_s = in_scr_s && (cx_r == H_END_LAST);

    assign pix_req_s  = in_scr_s && video_en;
    assign pix_req    = pix_req_s;
    assign invalidate = pix_req_s && (sx_r == SX_LAST) && (sy_r == SY_LAST);
    assign x_coord    = x_r;
    assign y_coord    = y_r;

    // Raster position: cx runs every clock, cy advances on each line wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_r <= '0;
            cy_r <= '0;
        end else begin
            if (h_wrap_s) begin
                cx_r <= '0;
                if (cy_r == V_LAST) begin
                    cy_r <= '0;
                end else begin
                    cy_r <= cy_r + CYW'(1'b1);
                end
            end else begin
                cx_r <= cx_r + CXW'(1'b1);
                cy_r <= cy_r;
            end
        end
    end

    // Horizontal replication: hold each logical x for SCALE_X clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            sx_r <= '0;
            x_r  <= '0;
        end else if (in_scr_s) begin
            if (sx_r == SX_LAST) begin
                sx_r <= '0;
                x_r  <= (x_r == X_LAST) ? '0 : x_r + XW'(1'b1);
            end else begin
                sx_r <= sx_r + SXW'(1'b1);
                x_r  <= x_r;
            end
        end else if (!in_h_s) begin
            sx_r <= '0;
            x_r  <= '0;
        end else begin
            sx_r <= sx_r;
            x_r  <= x_r;
        end
    end

    // Vertical replication: advance once per screen line, on its last pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sy_r <= '0;
            y_r  <= '0;
        end else if (line_last_s) begin
            if (sy_r == SY_LAST) begin
                sy_r <= '0;
                y_r  <= (y_r == Y_LAST) ? '0 : y_r + YW'(1'b1);
            end else begin
                sy_r <= sy_r + SYW'(1'b1);
                y_r  <= y_r;
            end
        end else if (!in_v_s) begin
            sy_r <= '0;
            y_r  <= '0;
        end else begin
            sy_r <= sy_r;
            y_r  <= y_r;
        end
    end

    // Next pin values: buffer colour inside the screen, border in the rest of
    // the active area, black in blanking or when video is disabled.
    always_comb begin
        rgb_nxt_s = '0;
        if (!video_en) begin
            rgb_nxt_s = '0;
        end else if (in_scr_s) begin
            rgb_nxt_s = pix_data;
        end else if (active_s) begin
            rgb_nxt_s = BORDER_COLOR;
        end else begin
            rgb_nxt_s = '0;
        end
        hsync_nxt_s = ((cx_r >= HS_BEG) && (cx_r < HS_END)) ? HS_ON : ~HS_ON;
        vsync_nxt_s = ((cy_r >= VS_BEG) && (cy_r < VS_END)) ? VS_ON : ~VS_ON;
    end

    // Output register stage, one clock behind the raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb         <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            frame_start <= 1'b0;
        end else begin
            rgb         <= rgb_nxt_s;
            hsync       <= hsync_nxt_s;
            vsync       <= vsync_nxt_s;
            frame_start <= (cx_r == '0) && (cy_r == '0);
        end
    end

endmodule

// File: tb/tb_vga_scaled_timing.sv
// Bench for vga_scaled_timing on a reduced mode (57x39 raster, 8x6 screen at
// 3x4 scale, odd margins, mixed sync polarity, non-zero border). Expected
// values come from the absolute cycle count since reset, using div/mod.
module tb_vga_scaled_timing;

    localparam int HA = 41, HF = 4, HS = 6, HB = 6;
    localparam int VA = 31, VF = 2, VS = 3, VB = 3;
    localparam int HP = 1, VP = 0;
    localparam int SW = 8, SH = 6, SX = 3, SY = 4, CW = 8;
    localparam logic [CW-1:0] BC = 8'hE0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HOFF = (HA - SW * SX) / 2;
    localparam int VOFF = (VA - SH * SY) / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          video_en = 1'b0;
    logic [2:0]    x_coord;
    logic [2:0]    y_coord;
    logic          pix_req;
    logic          invalidate;
    logic [CW-1:0] pix_data;
    logic [CW-1:0] rgb;
    logic          hsync;
    logic          vsync;
    logic          frame_start;

    logic [CW-1:0] mem [SW*SH];

    int t = 0;
    int pass_cnt = 0;
    int chk_cnt = 0;
    logic [CW-1:0] exp_rgb;
    logic exp_hs, exp_vs, exp_fs;

    vga_scaled_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP),
        .SCREEN_W(SW), .SCREEN_H(SH), .SCALE_X(SX), .SCALE_Y(SY),
        .COLOR_W(CW), .BORDER_COLOR(BC)
    ) dut (
        .clk(clk), .reset(reset), .video_en(video_en),
        .x_coord(x_coord), .y_coord(y_coord),
        .pix_req(pix_req), .invalidate(invalidate),
        .pix_data(pix_data), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Buffer model: same-cycle lookup of the requested logical pixel.
    assign pix_data = mem[(int'(y_coord) * SW + int'(x_coord)) % (SW * SH)];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    endtask

    // One pixel clock: apply inputs, check outputs, then predict the
    // registered outputs for the next cycle.
    task automatic step(input logic en, input logic rst);
        int cx, cy, lx, ly;
        logic scr, inv;
        @(negedge clk);
        video_en = en;
        reset = rst;
        #1;
        cx = t % HT;
        cy = (t / HT) % VT;
        scr = (cx >= HOFF) && (cx < HOFF + SW * SX) && (cy >= VOFF) && (cy < VOFF + SH * SY);
        lx = (cx - HOFF) / SX;
        ly = (cy - VOFF) / SY;
        inv = scr && en && ((cx - HOFF) % SX == SX - 1) && ((cy - VOFF) % SY == SY - 1);
        check("pix_req", pix_req, scr && en);
        check("invalidate", invalidate, inv);
        if (scr) begin
            check("x_coord", x_coord, lx);
            check("y_coord", y_coord, ly);
        end
        check("rgb", rgb, exp_rgb);
        check("hsync", hsync, exp_hs);
        check("vsync", vsync, exp_vs);
        check("frame_start", frame_start, exp_fs);
        if (rst) begin
            exp_rgb = '0;
            exp_hs  = (HP == 0);
            exp_vs  = (VP == 0);
            exp_fs  = 1'b0;
            t = 0;
        end else begin
            if (!en)
                exp_rgb = '0;
            else if (scr)
                exp_rgb = mem[ly * SW + lx];
            else if (cx < HA && cy < VA)
                exp_rgb = BC;
            else
                exp_rgb = '0;
            exp_hs = (cx >= HA + HF && cx < HA + HF + HS) ? (HP != 0) : (HP == 0);
            exp_vs = (cy >= VA + VF && cy < VA + VF + VS) ? (VP != 0) : (VP == 0);
            exp_fs = (cx == 0) && (cy == 0);
            t++;
        end
    endtask

    initial begin
        logic en;
        for (int i = 0; i < SW * SH; i++) mem[i] = CW'($urandom_range(0, 255));
        reset = 1'b1;
        video_en = 1'b0;
        repeat (2) @(posedge clk);
        exp_rgb = '0;
        exp_hs  = (HP == 0);
        exp_vs  = (VP == 0);
        exp_fs  = 1'b0;
        t = 0;

        // Steady video for more than one full frame.
        for (int i = 0; i < HT * VT + 300; i++) step(1'b1, 1'b0);

        // Video enable toggled at random points.
        en = 1'b1;
        for (int i = 0; i < HT * VT; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            step(en, 1'b0);
        end

        // Directed drop/raise inside a screen line, then reset mid-frame.
        while (!((t % HT) == HOFF + 2 && ((t / HT) % VT) == VOFF + 5)) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Restarted frame with randomized enable and fresh buffer contents.
        for (int i = 0; i < SW * SH; i++) mem[i] = CW'($urandom);
        en = 1'b1;
        for (int i = 0; i < HT * VT + 100; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            step(en, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
